// File: rtl/chacha_ks_stream.sv
// chacha_ks_stream: ChaCha keystream source with block prefetch and width
// conversion. An iterative ChaCha20 core (chacha_core, one round per clock)
// generates 512-bit blocks into a FIFO_DEPTH-block buffer. The buffer is
// served as OUT_W-bit words over a valid/ready handshake.
//
// Optional feature macro: CHACHA_KS_CTR_GUARD_EN
//   defined   - after the block for counter 32'hFFFF_FFFF is buffered,
//               ctr_err is set and generation halts until the next cfg_we.
//   undefined - the block counter wraps to 0 and ctr_err is tied low.
//
// Block layout (both the core and the buffer): state word j sits at
// bits [j*32 +: 32]. Word 12 is the block counter, 13..15 the nonce.

// ---------------------------------------------------------------------------
// chacha_core: 20-round ChaCha block function, one round per clock.
// init/next start a block from the current inputs; data_out_valid pulses
// for one cycle when data_out holds (state + input state) ^ data_in.
// ---------------------------------------------------------------------------
module chacha_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         next,
  input  logic [255:0] key,
  input  logic [63:0]  iv,
  input  logic [63:0]  ctr,
  input  logic [511:0] data_in,
  output logic         ready,
  output logic [511:0] data_out,
  output logic         data_out_valid
);

  localparam logic [4:0] NUM_ROUNDS = 5'd20;

  typedef logic [15:0][31:0] state_t;

  state_t       start_state;
  state_t       x_q;
  state_t       orig_q;
  state_t       round_out;
  logic [511:0] final_sum;
  logic [511:0] din_q;
  logic [4:0]   rnd_q;
  logic         busy_q;

  // One ChaCha quarter round; returns {d, c, b, a}.
  function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                 input logic [31:0] b_in,
                                                 input logic [31:0] c_in,
                                                 input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  // One round: column round when diag=0, diagonal round when diag=1.
  // The four quarter rounds touch disjoint words, so applying them in
  // sequence on a copy is equivalent to applying them in parallel.
  function automatic state_t chacha_round(input state_t s, input logic diag);
    state_t       r;
    logic [127:0] q;
    int           bi, ci, di;
    r = s;
    for (int i = 0; i < 4; i++) begin
      bi = 4  + (diag ? ((i + 1) % 4) : i);
      ci = 8  + (diag ? ((i + 2) % 4) : i);
      di = 12 + (diag ? ((i + 3) % 4) : i);
      q  = quarter_round(r[i], r[bi], r[ci], r[di]);
      r[i]  = q[31:0];
      r[bi] = q[63:32];
      r[ci] = q[95:64];
      r[di] = q[127:96];
    end
    return r;
  endfunction

  // Assemble the input state from constants, key, counter and iv.
  // NOTE: every variable written in a combinational block is assigned on
  // every path (defaults first where needed), otherwise a latch is inferred.
  always_comb begin
    start_state[0] = 32'h6170_7865;
    start_state[1] = 32'h3320_646e;
    start_state[2] = 32'h7962_2d32;
    start_state[3] = 32'h6b20_6574;
    for (int i = 0; i < 8; i++) start_state[4 + i] = key[i*32 +: 32];
    start_state[12] = ctr[31:0];
    start_state[13] = ctr[63:32];
    start_state[14] = iv[31:0];
    start_state[15] = iv[63:32];
  end

  // Round datapath and the final feed-forward addition.
  always_comb begin
    round_out = chacha_round(x_q, rnd_q[0]);
    for (int i = 0; i < 16; i++) final_sum[i*32 +: 32] = x_q[i] + orig_q[i];
  end

  assign ready = !busy_q;

  // Round counter, working state and the one-cycle result pulse.
  // NOTE: clocked state uses non-blocking (<=) assignments so every register
  // samples pre-edge values; blocking (=) here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q            <= '0;
      orig_q         <= '0;
      din_q          <= '0;
      rnd_q          <= '0;
      busy_q         <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      if (init || next) begin
        x_q    <= start_state;
        orig_q <= start_state;
        din_q  <= data_in;
        rnd_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (rnd_q == NUM_ROUNDS) begin
          data_out       <= final_sum ^ din_q;
          data_out_valid <= 1'b1;
          busy_q         <= 1'b0;
        end else begin
          x_q   <= round_out;
          rnd_q <= rnd_q + 5'd1;
        end
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// chacha_ks_stream: top level.
// ---------------------------------------------------------------------------
module chacha_ks_stream #(
  parameter int OUT_W      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [255:0]                    chacha_key,
  input  logic [95:0]                     chacha_nonce,
  input  logic [31:0]                     chacha_ctr_init,
  input  logic                            cfg_we,
  input  logic                            ks_ready,
  output logic                            ks_valid,
  output logic [OUT_W-1:0]                ks_data,
  output logic                            ks_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            ctr_err
);

  localparam int WORDS = 512 / OUT_W;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_INC
  } gen_state_e;

  gen_state_e   state_q, state_d;

  logic [255:0] key_reg;
  logic [95:0]  nonce_reg;
  logic [31:0]  ctr_reg;
  logic         discard_q;
  logic         halted;

  logic [511:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [IW-1:0] word_idx;

  logic         core_init;
  logic         core_ready;
  logic         core_valid;
  logic [511:0] core_data;

  logic         slot_free;
  logic         push;
  logic         fire;
  logic         pop;

  // Pointer increment that stays at zero for a single-entry buffer.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (FIFO_DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  chacha_core u_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .init           (core_init),
    .next           (1'b0),
    .key            (key_reg),
    .iv             (nonce_reg[95:32]),
    .ctr            ({nonce_reg[31:0], ctr_reg}),
    .data_in        ('0),
    .ready          (core_ready),
    .data_out       (core_data),
    .data_out_valid (core_valid)
  );

  // Only one block is ever in flight, and REQ waits for a free slot, so a
  // push can never land on a full buffer. cfg_we overrides both sides.
  assign slot_free  = (count != LW'(FIFO_DEPTH));
  assign push       = (state_q == ST_WAIT) && core_valid && !discard_q && !cfg_we;
  assign ks_valid   = (count != '0);
  assign ks_last    = ks_valid && (word_idx == IW'(WORDS - 1));
  assign fire       = ks_valid && ks_ready && !cfg_we;
  assign pop        = fire && ks_last;
  assign ks_data    = ks_valid ? mem[rd_ptr][word_idx*OUT_W +: OUT_W] : '0;
  assign fifo_level = count;

`ifdef CHACHA_KS_CTR_GUARD_EN
  logic err_q;

  // Sticky exhaustion flag; it also halts new init pulses until cfg_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (cfg_we) begin
      err_q <= 1'b0;
    end else if (push && (ctr_reg == 32'hFFFF_FFFF)) begin
      err_q <= 1'b1;
    end
  end

  assign halted  = err_q;
  assign ctr_err = err_q;
`else
  assign halted  = 1'b0;
  assign ctr_err = 1'b0;
`endif

  // Generator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Generator next state and init pulse. cfg_we re-arms from any state; a
  // reconfiguration during WAIT must let the aborted block drain from the
  // core first, so the FSM stays in WAIT until it arrives.
  always_comb begin
    state_d   = state_q;
    core_init = 1'b0;
    if (cfg_we) begin
      state_d = ((state_q == ST_WAIT) && !core_valid) ? ST_WAIT : ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_REQ: begin
          if (core_ready && slot_free && !halted) begin
            core_init = 1'b1;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_valid) state_d = discard_q ? ST_REQ : ST_INC;
        end
        ST_INC:  state_d = ST_REQ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Marks the in-flight block as stale when cfg_we lands during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_q <= 1'b0;
    end else if (cfg_we) begin
      discard_q <= (state_q == ST_WAIT) && !core_valid;
    end else if ((state_q == ST_WAIT) && core_valid) begin
      discard_q <= 1'b0;
    end
  end

  // Configuration, block counter, buffer pointers and output word index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg   <= '0;
      nonce_reg <= '0;
      ctr_reg   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_idx  <= '0;
    end else if (cfg_we) begin
      key_reg   <= chacha_key;
      nonce_reg <= chacha_nonce;
      ctr_reg   <= chacha_ctr_init;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      word_idx  <= '0;
    end else begin
      if (state_q == ST_INC) ctr_reg <= ctr_reg + 32'd1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (fire) word_idx <= ks_last ? '0 : word_idx + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Block buffer storage.
  // NOTE: the storage array is deliberately not reset; valid data is tracked
  // by count/pointers, and a reset on wide memories only costs logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= core_data;
  end

endmodule
